// File: rtl/mem_bus_decoder.sv
// Memory-bus decoder and response mux: base/mask slave map, lowest-index priority,
// stalled-slave watchdog with fault response, and fault address/count capture.
module mem_bus_decoder #(
    parameter int unsigned NUM_SLAVES     = 6,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_WIDTH-1:0]            address_in,
    input  logic                             read_in,
    input  logic [DATA_WIDTH/8-1:0]          write_mask_in,
    output logic [DATA_WIDTH-1:0]            read_value_out,
    output logic                             ready_out,
    output logic                             fault_out,
    output logic [NUM_SLAVES-1:0]            sel_out,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_rdata_in,
    input  logic [NUM_SLAVES-1:0]            slave_ready_in,
    output logic [ADDR_WIDTH-1:0]            fault_addr_out,
    output logic [7:0]                       fault_count_out
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StTimeout} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   fault_addr_q;
    logic [7:0]              fault_count_q;

    logic                    req;
    logic [NUM_SLAVES-1:0]   hit, win_oh;
    logic                    any_hit, win_ready, log_fault;
    logic [DATA_WIDTH-1:0]   win_rdata;

    assign req = read_in | (|write_mask_in);

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit[i] = (address_in & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                     SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Isolate the lowest set bit: overlapping regions resolve to the lowest index.
    assign win_oh    = hit & (~hit + 1'b1);
    assign any_hit   = |hit;
    assign win_ready = |(win_oh & slave_ready_in);

    always_comb begin
        win_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (win_oh[i]) win_rdata = slave_rdata_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sel_out        = '0;
        ready_out      = 1'b0;
        fault_out      = 1'b0;
        read_value_out = '0;
        log_fault      = 1'b0;
        unique case (state_q)
            StIdle, StBusy: begin
                if (!req) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (!any_hit) begin
                    ready_out = 1'b1;
                    fault_out = 1'b1;
                    log_fault = 1'b1;
                    state_d   = StIdle;
                    cnt_d     = '0;
                end else begin
                    sel_out = win_oh;
                    if (win_ready) begin
                        ready_out      = 1'b1;
                        read_value_out = win_rdata;
                        state_d        = StIdle;
                        cnt_d          = '0;
                    end else if (state_q == StIdle) begin
                        if (TIMEOUT_CYCLES != 0) begin
                            state_d = StBusy;
                            cnt_d   = CntW'(1);
                        end
                    end else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
                        state_d = StTimeout;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StTimeout: begin
                ready_out = 1'b1;
                fault_out = 1'b1;
                log_fault = 1'b1;
                state_d   = StIdle;
                cnt_d     = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            fault_addr_q  <= '0;
            fault_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (log_fault) begin
                fault_addr_q <= address_in;
                if (fault_count_q != 8'hFF) fault_count_q <= fault_count_q + 8'd1;
            end
        end
    end

    assign fault_addr_out  = fault_addr_q;
    assign fault_count_out = fault_count_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed bench for mem_bus_decoder: decode, priority, watchdog, fault logging, reset.
module tb_mem_bus_decoder;

    localparam int NS = 6;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     address_in;
    logic              read_in;
    logic [DW/8-1:0]   write_mask_in;
    logic [DW-1:0]     read_value_out;
    logic              ready_out;
    logic              fault_out;
    logic [NS-1:0]     sel_out;
    logic [NS*DW-1:0]  slave_rdata_in;
    logic [NS-1:0]     slave_ready_in;
    logic [AW-1:0]     fault_addr_out;
    logic [7:0]        fault_count_out;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_decoder #(
        .NUM_SLAVES    (NS),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .SLAVE_BASE    ({32'h4000_0000, 32'h3000_0000, 32'h2000_0000,
                         32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK    ({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                         32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .address_in     (address_in),
        .read_in        (read_in),
        .write_mask_in  (write_mask_in),
        .read_value_out (read_value_out),
        .ready_out      (ready_out),
        .fault_out      (fault_out),
        .sel_out        (sel_out),
        .slave_rdata_in (slave_rdata_in),
        .slave_ready_in (slave_ready_in),
        .fault_addr_out (fault_addr_out),
        .fault_count_out(fault_count_out)
    );

    task automatic idle_bus();
        read_in        = 1'b0;
        write_mask_in  = '0;
        address_in     = '0;
        slave_ready_in = '0;
        for (int i = 0; i < NS; i++) slave_rdata_in[i*DW +: DW] = 32'hA000_0000 | i;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_bus();
        #12;
        n_cmp += 6;
        if (sel_out !== 6'h0) begin n_fail++; $display("FAIL reset_sel got %h want 00", sel_out); end
        if (ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready_out); end
        if (fault_out !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault_out); end
        if (read_value_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata got %h want 0", read_value_out);
        end
        if (fault_addr_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_faddr got %h want 0", fault_addr_out);
        end
        if (fault_count_out !== 8'h0) begin
            n_fail++; $display("FAIL reset_fcnt got %0d want 0", fault_count_out);
        end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_zero_wait_read();
        @(negedge clk);
        address_in = 32'h0000_0010; read_in = 1'b1;
        slave_rdata_in[0 +: DW] = 32'hDEAD_BEEF; slave_ready_in = 6'h01;
        #1;
        n_cmp += 4;
        if (sel_out !== 6'h01) begin n_fail++; $display("FAIL zw_sel got %h want 01", sel_out); end
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL zw_ready got %b want 1", ready_out); end
        if (fault_out !== 1'b0) begin n_fail++; $display("FAIL zw_fault got %b want 0", fault_out); end
        if (read_value_out !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL zw_rdata got %h want deadbeef", read_value_out);
        end
        @(negedge clk) idle_bus();
    endtask

    task automatic test_unmapped();
        @(negedge clk);
        address_in = 32'h0500_0000; read_in = 1'b1; slave_ready_in = '1;
        #1;
        n_cmp += 4;
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL um_ready got %b want 1", ready_out); end
        if (fault_out !== 1'b1) begin n_fail++; $display("FAIL um_fault got %b want 1", fault_out); end
        if (sel_out !== 6'h0) begin n_fail++; $display("FAIL um_sel got %h want 00", sel_out); end
        if (read_value_out !== 32'h0) begin
            n_fail++; $display("FAIL um_rdata got %h want 0", read_value_out);
        end
        @(negedge clk) idle_bus();
        #1;
        n_cmp += 2;
        if (fault_addr_out !== 32'h0500_0000) begin
            n_fail++; $display("FAIL um_faddr got %h want 05000000", fault_addr_out);
        end
        if (fault_count_out !== 8'd1) begin
            n_fail++; $display("FAIL um_fcnt got %0d want 1", fault_count_out);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        address_in = 32'h1000_0010; read_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp += 2;
            if (sel_out !== 6'h02) begin
                n_fail++; $display("FAIL to_sel cyc%0d got %h want 02", k, sel_out);
            end
            if (ready_out !== 1'b0) begin
                n_fail++; $display("FAIL to_ready cyc%0d got %b want 0", k, ready_out);
            end
            @(negedge clk);
        end
        #1;
        n_cmp += 4;
        if (sel_out !== 6'h0) begin n_fail++; $display("FAIL to_fsel got %h want 00", sel_out); end
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL to_fready got %b want 1", ready_out); end
        if (fault_out !== 1'b1) begin n_fail++; $display("FAIL to_ffault got %b want 1", fault_out); end
        if (read_value_out !== 32'h0) begin
            n_fail++; $display("FAIL to_frdata got %h want 0", read_value_out);
        end
        @(negedge clk) idle_bus();
        #1;
        n_cmp += 3;
        if (ready_out !== 1'b0) begin n_fail++; $display("FAIL to_idle got %b want 0", ready_out); end
        if (fault_count_out !== 8'd2) begin
            n_fail++; $display("FAIL to_fcnt got %0d want 2", fault_count_out);
        end
        if (fault_addr_out !== 32'h1000_0010) begin
            n_fail++; $display("FAIL to_faddr got %h want 10000010", fault_addr_out);
        end
    endtask

    // Ready on stall cycle 3 (4th) and on cycle 4 (cnt == TIMEOUT_CYCLES boundary).
    task automatic test_late_ready();
        for (int rc = 3; rc <= 4; rc++) begin
            @(negedge clk);
            address_in = 32'h1000_0020; read_in = 1'b1;
            slave_rdata_in[1*DW +: DW] = 32'h1234_5678 + rc;
            for (int k = 0; k < rc; k++) @(negedge clk);
            slave_ready_in = 6'h02;
            #1;
            n_cmp += 3;
            if (ready_out !== 1'b1) begin
                n_fail++; $display("FAIL lr%0d_ready got %b want 1", rc, ready_out);
            end
            if (fault_out !== 1'b0) begin
                n_fail++; $display("FAIL lr%0d_fault got %b want 0", rc, fault_out);
            end
            if (read_value_out !== 32'h1234_5678 + rc) begin
                n_fail++; $display("FAIL lr%0d_rdata got %h want %h", rc, read_value_out,
                                   32'h1234_5678 + rc);
            end
            @(negedge clk) idle_bus();
            @(negedge clk);
            n_cmp += 1;
            if (fault_count_out !== 8'd2) begin
                n_fail++; $display("FAIL lr%0d_fcnt got %0d want 2", rc, fault_count_out);
            end
        end
    endtask

    task automatic test_overlap_and_write();
        @(negedge clk);
        address_in = 32'h2000_0040; read_in = 1'b1; slave_ready_in = 6'h0C;
        slave_rdata_in[2*DW +: DW] = 32'h2222_2222;
        slave_rdata_in[3*DW +: DW] = 32'hFFFF_FFFF;
        #1;
        n_cmp += 2;
        if (sel_out !== 6'h04) begin n_fail++; $display("FAIL ov_sel got %h want 04", sel_out); end
        if (read_value_out !== 32'h2222_2222) begin
            n_fail++; $display("FAIL ov_rdata got %h want 22222222", read_value_out);
        end
        @(negedge clk);
        read_in = 1'b0; write_mask_in = 4'b0011; address_in = 32'h3000_0008;
        slave_ready_in = 6'h10;
        #1;
        n_cmp += 3;
        if (sel_out !== 6'h10) begin n_fail++; $display("FAIL wr_sel got %h want 10", sel_out); end
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL wr_ready got %b want 1", ready_out); end
        if (read_value_out !== 32'hA000_0004) begin
            n_fail++; $display("FAIL wr_rdata got %h want a0000004", read_value_out);
        end
        @(negedge clk);
        address_in = 32'h7700_0000; slave_ready_in = '1;
        #1;
        n_cmp += 2;
        if (sel_out !== 6'h0) begin n_fail++; $display("FAIL fw_sel got %h want 00", sel_out); end
        if (fault_out !== 1'b1) begin n_fail++; $display("FAIL fw_fault got %b want 1", fault_out); end
        @(negedge clk) idle_bus();
        #1;
        n_cmp += 1;
        if (fault_count_out !== 8'd3) begin
            n_fail++; $display("FAIL fw_fcnt got %0d want 3", fault_count_out);
        end
    endtask

    task automatic test_saturate_and_reset();
        int cyc;
        @(negedge clk);
        address_in = 32'h0500_1234; read_in = 1'b1;
        for (int k = 0; k < 300; k++) @(negedge clk);
        idle_bus();
        #1;
        n_cmp += 1;
        if (fault_count_out !== 8'd255) begin
            n_fail++; $display("FAIL sat_fcnt got %0d want 255", fault_count_out);
        end
        @(negedge clk);
        address_in = 32'h1000_0000; read_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp += 4;
        if (fault_count_out !== 8'd0) begin
            n_fail++; $display("FAIL rst_fcnt got %0d want 0", fault_count_out);
        end
        if (fault_addr_out !== 32'h0) begin
            n_fail++; $display("FAIL rst_faddr got %h want 0", fault_addr_out);
        end
        if (ready_out !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", ready_out); end
        if (sel_out !== 6'h02) begin n_fail++; $display("FAIL rst_selreq got %h want 02", sel_out); end
        read_in = 1'b0;
        #1;
        n_cmp += 1;
        if (sel_out !== 6'h0) begin n_fail++; $display("FAIL rst_seldrop got %h want 00", sel_out); end
        @(negedge clk) reset = 1'b1;
        // Watchdog must restart from zero after reset: fault lands exactly on cycle 5.
        @(negedge clk);
        read_in = 1'b1;
        cyc = 0;
        #1;
        while (!ready_out && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        n_cmp += 2;
        if (cyc !== 5) begin n_fail++; $display("FAIL rst_tocyc got %0d want 5", cyc); end
        if (fault_out !== 1'b1) begin n_fail++; $display("FAIL rst_tofault got %b want 1", fault_out); end
        @(negedge clk) idle_bus();
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_unmapped();
        test_timeout();
        test_late_ready();
        test_overlap_and_write();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
